level_sequencer: RTL and testbench
==================================

// Module: level_sequencer
// PURPOSE
//  Sequences levels for the map datapath. Per level it streams 150 tiles from the level ROM into the 600-bit map bus.
//  It counts collectible tiles (COIN/POWERUP), pulses next_level so the map unit clears its picked state, then counts
//  pickups until the level is cleared. After the last level it raises game_won. Sits between the level ROM and map_ctl_unit.
// PARAMETERS
//  TILES        150      tiles per level (15x10 grid)
//  TILE_W       4        bits per tile type
//  LEVELS       4        number of levels stored in ROM
//  ROM_AW       10       ROM address width (LEVELS*TILES must fit)
//  CLEAR_DELAY  1000000  cycles held in CLEAR before the next level loads
// PORTS
//  clk          in   1               system clock
//  rst          in   1               asynchronous reset, active-low
//  start        in   1               1-cycle pulse: begin the game at level 0 (honoured in IDLE/DONE only)
//  pickup       in   1               1-cycle pulse from the map unit per collected item
//  rom_addr     out  ROM_AW          level ROM address; ROM data valid 1 cycle later
//  rom_data     in   TILE_W          tile type read from the ROM
//  map          out  TILES*TILE_W    tile map; tile i occupies map[i*4+:4]
//  next_level   out  1               1-cycle pulse after load completes (re-inits picked flags)
//  level        out  4               current level index, 0-based
//  busy         out  1               high in LOAD and ARM
//  remaining    out  8               collectibles not yet picked this level
//  game_won     out  1               high in DONE
// BEHAVIOUR
//  - Reset (rst=0, async) forces: state=IDLE, map=0, rom_addr=0, next_level=0, level=0, busy=0, remaining=0,
//    game_won=0, tile index=0, delay counter=0.
//  - States: IDLE, LOAD, ARM, PLAY, CLEAR, DONE. All outputs are registered.
//  - IDLE: on start -> LOAD with level=0.
//  - Entering LOAD: map<=0, remaining<=0, idx<=0.
//  - LOAD: rom_addr = level*TILES + idx. idx advances every cycle from 0 to TILES-1.
//    - On the following cycle, map[(idx_d)*4+:4] <= rom_data.
//    - If rom_data is 2 or 3, remaining is incremented (saturates at 255).
//    - LOAD lasts TILES+1 = 151 cycles, then -> ARM.
//  - ARM: next_level=1 for exactly 1 cycle, then -> PLAY.
//  - PLAY: each pickup decrements remaining (floor 0).
//    - When remaining==0 -> CLEAR; this includes a level with zero collectibles, which exits after 1 cycle of PLAY.
//    - pickup in any state other than PLAY is ignored.
//    - pickup and the transition to CLEAR in the same cycle: the decrement is applied first.
//  - CLEAR: the counter runs 0..CLEAR_DELAY-1 and the map stays frozen. Then:
//    - if level==LEVELS-1 -> DONE;
//    - else level<=level+1 -> LOAD.
//  - DONE: game_won=1 and the map is held. start -> LOAD with level=0 and game_won<=0.
//  - start outside IDLE/DONE is ignored. rst mid-LOAD leaves a partial map, which reset then clears to 0.
//  - Widths: rom_addr is computed in ROM_AW bits (level*150+idx <= 599). idx is 8 bits. remaining is 8 bits.
// CONFIGURATION
//  - LEVEL_SKIP_EN defined: adds input `skip` (1-cycle pulse). skip in PLAY forces remaining<=0 and -> CLEAR on the
//    next cycle. skip is ignored in other states.
//  - LEVEL_SKIP_EN undefined: no `skip` port; a level ends only when remaining reaches 0.
// STRUCTURE
//  - Shared package/header holds:
//    - tile type constants BLANK=0, WALL=1, COIN=2, POWERUP=3;
//    - MAP_COLS=15, MAP_ROWS=10, TILE_W=4;
//    - the state encoding, so map_ctl_unit and the debug overlay share it.
//  - No sub-module. The level ROM (level_rom) is instantiated outside, next to this block, and is not part of it.
// TESTING
//  1. rst low then high, start at cycle 10 -> rom_addr walks 0..149; next_level pulses once at start+152; busy falls with it.
//  2. Level 0 ROM holds 3 coins + 1 powerup -> remaining=4 in PLAY; 4 pickup pulses -> remaining 0, state CLEAR.
//  3. Level 1 has no collectibles (CLEAR_DELAY=8 in sim) -> 1 PLAY cycle, CLEAR 8 cycles, then LOAD with rom_addr=300.
//  4. pickup during LOAD and start during PLAY -> remaining and level unchanged.
//  5. Clear level 3 (LEVELS=4) -> game_won=1 and level=3 after CLEAR; start -> level=0, game_won=0, rom_addr=0.
//  6. rst asserted at idx=70 of LOAD -> map=0, state IDLE immediately (async); with LEVEL_SKIP_EN, skip in PLAY -> CLEAR next cycle.

Source files
------------

// File: rtl/level_sequencer_pkg.sv
// Shared tile-type constants, map geometry and sequencer state encoding
// for the level sequencer, map_ctl_unit and the debug overlay.
package level_sequencer_pkg;

  localparam int TILE_W   = 4;
  localparam int MAP_COLS = 15;
  localparam int MAP_ROWS = 10;

  localparam logic [TILE_W-1:0] BLANK   = 4'd0;
  localparam logic [TILE_W-1:0] WALL    = 4'd1;
  localparam logic [TILE_W-1:0] COIN    = 4'd2;
  localparam logic [TILE_W-1:0] POWERUP = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_PLAY,
    ST_CLEAR,
    ST_DONE
  } state_t;

  function automatic logic is_collectible(input logic [TILE_W-1:0] t);
    return (t == COIN) || (t == POWERUP);
  endfunction

endpackage

// File: rtl/level_sequencer.sv
// Level sequencer: streams each level from the level ROM into the map bus, counts
// collectibles and pickups, and advances levels. Optional `skip` input under LEVEL_SKIP_EN.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int TILES       = MAP_COLS * MAP_ROWS,
  parameter int TILE_W      = 4,
  parameter int LEVELS      = 4,
  parameter int ROM_AW      = 10,
  parameter int CLEAR_DELAY = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pickup,
`ifdef LEVEL_SKIP_EN
  input  logic                     skip,
`endif
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [TILE_W-1:0]        rom_data,
  output logic [TILES*TILE_W-1:0]  map,
  output logic                     next_level,
  output logic [3:0]               level,
  output logic                     busy,
  output logic [7:0]               remaining,
  output logic                     game_won
);

  localparam int MAP_W  = TILES * TILE_W;
  localparam int MAP_BW = $clog2(MAP_W);
  localparam int CNT_W  = (CLEAR_DELAY > 1) ? $clog2(CLEAR_DELAY) : 1;

  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAP_W-1:0]    map_q, map_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [3:0]          level_q, level_d;
  logic [7:0]          rem_q, rem_d;
  logic                next_level_q, busy_q, won_q;
  logic                load_entry;
  logic [MAP_BW-1:0]   wr_bit;
  logic                skip_w;

`ifdef LEVEL_SKIP_EN
  assign skip_w = skip;
`else
  assign skip_w = 1'b0;
`endif

  // ROM data arrives one cycle after its address, so LOAD writes tile idx-1.
  assign wr_bit = MAP_BW'(idx_q - 8'd1) * MAP_BW'(TILE_W);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    map_d      = map_q;
    rom_addr_d = rom_addr_q;
    level_d    = level_q;
    rem_d      = rem_q;
    load_entry = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          level_d    = 4'd0;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (idx_q != 8'd0) begin
          map_d[wr_bit +: TILE_W] = rom_data;
          if (is_collectible(rom_data) && (rem_q != 8'hFF)) rem_d = rem_q + 8'd1;
        end
        if (idx_q == 8'(TILES)) begin
          state_d = ST_ARM;
        end else begin
          idx_d = idx_q + 8'd1;
          if (idx_q < 8'(TILES - 1)) rom_addr_d = rom_addr_q + 1'b1;
        end
      end
      ST_ARM: state_d = ST_PLAY;
      ST_PLAY: begin
        if (pickup && (rem_q != 8'd0)) rem_d = rem_q - 8'd1;
        if (skip_w) rem_d = 8'd0;
        // Decrement lands first, so the final pickup also triggers the exit.
        if (rem_d == 8'd0) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_DELAY - 1)) begin
          if (level_q == 4'(LEVELS - 1)) begin
            state_d = ST_DONE;
          end else begin
            level_d    = level_q + 4'd1;
            load_entry = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_entry) begin
      state_d    = ST_LOAD;
      idx_d      = 8'd0;
      map_d      = '0;
      rem_d      = 8'd0;
      rom_addr_d = ROM_AW'(level_d) * ROM_AW'(TILES);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 8'd0;
      cnt_q        <= '0;
      map_q        <= '0;
      rom_addr_q   <= '0;
      level_q      <= 4'd0;
      rem_q        <= 8'd0;
      next_level_q <= 1'b0;
      busy_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      map_q        <= map_d;
      rom_addr_q   <= rom_addr_d;
      level_q      <= level_d;
      rem_q        <= rem_d;
      next_level_q <= (state_q == ST_ARM);
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_ARM);
      won_q        <= (state_d == ST_DONE);
    end
  end

  assign rom_addr   = rom_addr_q;
  assign map        = map_q;
  assign next_level = next_level_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign remaining  = rem_q;
  assign game_won   = won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with a behavioural level ROM and CLEAR_DELAY=8.
module tb_level_sequencer;

  localparam int TILES       = 150;
  localparam int TILE_W      = 4;
  localparam int LEVELS      = 4;
  localparam int ROM_AW      = 10;
  localparam int CLEAR_DELAY = 8;
  localparam int MAP_W       = TILES * TILE_W;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic start  = 1'b0;
  logic pickup = 1'b0;
`ifdef LEVEL_SKIP_EN
  logic skip   = 1'b0;
`endif
  logic [ROM_AW-1:0] rom_addr;
  logic [TILE_W-1:0] rom_data = '0;
  logic [MAP_W-1:0]  map;
  logic              next_level;
  logic [3:0]        level;
  logic              busy;
  logic [7:0]        remaining;
  logic              game_won;

  logic [TILE_W-1:0] rom [0:1023];
  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int t;
    int addr;
    int busy;
    int nl;
    int rem;
  } vec_t;

  vec_t vec [10];

  level_sequencer #(
    .TILES(TILES), .TILE_W(TILE_W), .LEVELS(LEVELS),
    .ROM_AW(ROM_AW), .CLEAR_DELAY(CLEAR_DELAY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pickup(pickup),
`ifdef LEVEL_SKIP_EN
    .skip(skip),
`endif
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .map(map),
    .next_level(next_level),
    .level(level),
    .busy(busy),
    .remaining(remaining),
    .game_won(game_won)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_map(input string name, input logic [MAP_W-1:0] act, input logic [MAP_W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MAP_W-1:0] model_map(input int lvl, input int n);
    logic [MAP_W-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i*TILE_W +: TILE_W] = rom[lvl*TILES + i];
    return m;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_pickup();
    pickup = 1'b1;
    tick(1);
    pickup = 1'b0;
  endtask

  initial begin
    int t;
    int nlcnt;

    for (int i = 0; i < 1024; i++) rom[i] = 4'd0;
    rom[0] = 4'd3; rom[1] = 4'd1; rom[2] = 4'd1; rom[3] = 4'd1; rom[4] = 4'd1;
    rom[5] = 4'd2; rom[20] = 4'd2; rom[149] = 4'd2;
    rom[150] = 4'd1; rom[299] = 4'd1;
    rom[310] = 4'd2; rom[440] = 4'd2;
    rom[525] = 4'd3;

    // {t after start edge, rom_addr, busy, next_level, remaining}
    vec[0] = '{0,   0,   1, 0, 0};
    vec[1] = '{1,   1,   1, 0, 0};
    vec[2] = '{2,   2,   1, 0, 1};
    vec[3] = '{7,   7,   1, 0, 2};
    vec[4] = '{22,  22,  1, 0, 3};
    vec[5] = '{149, 149, 1, 0, 3};
    vec[6] = '{150, 149, 1, 0, 3};
    vec[7] = '{151, 149, 1, 0, 4};
    vec[8] = '{152, 149, 0, 1, 4};
    vec[9] = '{153, 149, 0, 0, 4};

    // Reset state
    tick(3);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk_map("rst_map", map, '0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_next_level", 32'(next_level), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_game_won", 32'(game_won), 0);
    rst = 1'b1;
    tick(6);
    chk("idle_busy", 32'(busy), 0);

    // Level 0 load walk, with a pickup and a start during LOAD
    pulse_start();
    t = 0;
    nlcnt = 0;
    for (int i = 0; i < 10; i++) begin
      while (t < vec[i].t) begin
        pickup = (t == 9);
        start  = (t == 30);
        tick(1);
        t++;
        if (next_level) nlcnt++;
      end
      pickup = 1'b0;
      start  = 1'b0;
      chk($sformatf("load_addr_t%0d", vec[i].t), 32'(rom_addr), vec[i].addr);
      chk($sformatf("load_busy_t%0d", vec[i].t), 32'(busy), vec[i].busy);
      chk($sformatf("load_nl_t%0d", vec[i].t), 32'(next_level), vec[i].nl);
      chk($sformatf("load_rem_t%0d", vec[i].t), 32'(remaining), vec[i].rem);
      chk($sformatf("load_level_t%0d", vec[i].t), 32'(level), 0);
      if (vec[i].t == 22) chk_map("partial_map_l0", map, model_map(0, 21));
    end
    chk("nl_pulse_count", 32'(nlcnt), 1);
    chk_map("full_map_l0", map, model_map(0, TILES));

    // start during PLAY is ignored
    pulse_start();
    chk("play_start_level", 32'(level), 0);
    chk("play_start_rem", 32'(remaining), 4);
    chk("play_start_busy", 32'(busy), 0);
    chk("play_start_addr", 32'(rom_addr), 149);

    for (int k = 1; k <= 4; k++) begin
      pulse_pickup();
      chk($sformatf("pickup_rem_%0d", k), 32'(remaining), 32'(4 - k));
      if (k < 4) tick(1);
    end
    pulse_pickup();
    chk("clear_pickup_rem", 32'(remaining), 0);
    tick(6);
    chk("clear_busy_l0", 32'(busy), 0);
    chk("clear_level_l0", 32'(level), 0);
    chk_map("clear_frozen_l0", map, model_map(0, TILES));
    tick(1);
    chk("l1_busy", 32'(busy), 1);
    chk("l1_level", 32'(level), 1);
    chk("l1_addr", 32'(rom_addr), 150);
    chk_map("l1_map_clear", map, '0);

    // Level 1: no collectibles
    tick(152);
    chk("l1_nl", 32'(next_level), 1);
    chk("l1_rem", 32'(remaining), 0);
    tick(1);
    chk("l1_nl_end", 32'(next_level), 0);
    tick(7);
    chk("l1_clear_busy", 32'(busy), 0);
    chk_map("l1_frozen", map, model_map(1, TILES));
    tick(1);
    chk("l2_addr", 32'(rom_addr), 300);
    chk("l2_level", 32'(level), 2);
    chk("l2_busy", 32'(busy), 1);

    // Level 2: two coins
    tick(152);
    chk("l2_rem", 32'(remaining), 2);
    pulse_pickup();
    tick(1);
    pulse_pickup();
    chk("l2_rem_end", 32'(remaining), 0);
    tick(8);
    chk("l3_addr", 32'(rom_addr), 450);
    chk("l3_level", 32'(level), 3);

    // Level 3: last level, one powerup
    tick(152);
    chk("l3_rem", 32'(remaining), 1);
    pulse_pickup();
    chk("l3_rem_end", 32'(remaining), 0);
    tick(7);
    chk("l3_won_early", 32'(game_won), 0);
    tick(1);
    chk("done_won", 32'(game_won), 1);
    chk("done_level", 32'(level), 3);
    chk("done_busy", 32'(busy), 0);
    tick(3);
    chk("done_won_held", 32'(game_won), 1);
    chk_map("done_map_held", map, model_map(3, TILES));
    pulse_start();
    chk("restart_level", 32'(level), 0);
    chk("restart_won", 32'(game_won), 0);
    chk("restart_addr", 32'(rom_addr), 0);
    chk("restart_busy", 32'(busy), 1);
    chk_map("restart_map", map, '0);

    // Async reset mid-LOAD
    tick(70);
    chk_map("midload_map", map, model_map(0, 69));
    chk("midload_addr", 32'(rom_addr), 70);
    #2;
    rst = 1'b0;
    #1;
    chk_map("async_rst_map", map, '0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_addr", 32'(rom_addr), 0);
    chk("async_rst_rem", 32'(remaining), 0);
    tick(2);
    rst = 1'b1;
    tick(3);
    pulse_pickup();
    chk("post_rst_idle_busy", 32'(busy), 0);
    chk("post_rst_idle_addr", 32'(rom_addr), 0);
    chk("post_rst_idle_rem", 32'(remaining), 0);

`ifdef LEVEL_SKIP_EN
    skip = 1'b1;
    tick(1);
    skip = 1'b0;
    chk("skip_idle_busy", 32'(busy), 0);
    pulse_start();
    tick(152);
    chk("skip_rem_start", 32'(remaining), 4);
    pulse_pickup();
    chk("skip_rem_pick", 32'(remaining), 3);
    skip = 1'b1;
    tick(1);
    skip = 1'b0;
    chk("skip_rem_zero", 32'(remaining), 0);
    tick(7);
    chk("skip_clear_busy", 32'(busy), 0);
    tick(1);
    chk("skip_next_busy", 32'(busy), 1);
    chk("skip_next_level", 32'(level), 1);
    chk("skip_next_addr", 32'(rom_addr), 150);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
